// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator controller and cab body.
package elevator_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_UP    = 2'b01;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_SERVE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        TRAVEL,
        DOOR,
        SETTLE
    } body_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/elevator_if.sv
// Command/status bundle between the elevator controller and the cab body.
interface elevator_if #(
    parameter int F_BITS = 2
);
    logic [1:0]        command;
    logic [F_BITS-1:0] cur_floor;
    logic              served_pulse;
    logic              moving;
    logic              dir_up;
    logic              door_open;
    logic              busy;

    modport master (
        output command,
        input  cur_floor, served_pulse, moving,
        input  dir_up, door_open, busy
    );

    modport slave (
        input  command,
        output cur_floor, served_pulse, moving,
        output dir_up, door_open, busy
    );
endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel, door and settle phases.
module elevator_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/elevator_body.sv
// Cab/motor model: executes up/down/serve commands and reports floor status.
module elevator_body
    import elevator_pkg::*;
#(
    parameter int N             = 4,
    parameter int F_BITS        = $clog2(N),
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6,
    parameter int SETTLE_CYCLES = 3
) (
    input logic       clk,
    input logic       rst_n,
    elevator_if.slave bus
);
    localparam int CNT_W =
        $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [F_BITS-1:0] TOP_FLOOR  = F_BITS'(N - 1);

    body_state_t       state, state_n;
    logic [F_BITS-1:0] floor_q, floor_n;
    logic              moving_q, moving_n;
    logic              dir_q, dir_n;
    logic              door_q, door_n;
    logic              pulse_q, pulse_n;
    logic              busy_q, busy_n;
    logic              load;
    logic [CNT_W-1:0]  load_value;
    logic              zero;

    elevator_timer #(.W(CNT_W)) timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (load_value),
        .zero       (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            floor_q  <= '0;
            moving_q <= 1'b0;
            dir_q    <= 1'b0;
            door_q   <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            floor_q  <= floor_n;
            moving_q <= moving_n;
            dir_q    <= dir_n;
            door_q   <= door_n;
            pulse_q  <= pulse_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        floor_n    = floor_q;
        moving_n   = moving_q;
        dir_n      = dir_q;
        door_n     = door_q;
        pulse_n    = 1'b0;
        load       = 1'b0;
        load_value = '0;
        unique case (state)
            IDLE: begin
                // Out-of-range moves fall through: the floor saturates.
                unique case (1'b1)
                    (bus.command == CMD_UP) && (floor_q != TOP_FLOOR): begin
                        state_n    = TRAVEL;
                        dir_n      = 1'b1;
                        moving_n   = 1'b1;
                        load       = 1'b1;
                        load_value = TRAVEL_LOAD;
                    end
                    (bus.command == CMD_DOWN) && (floor_q != '0): begin
                        state_n    = TRAVEL;
                        dir_n      = 1'b0;
                        moving_n   = 1'b1;
                        load       = 1'b1;
                        load_value = TRAVEL_LOAD;
                    end
                    (bus.command == CMD_SERVE): begin
                        state_n    = DOOR;
                        door_n     = 1'b1;
                        load       = 1'b1;
                        load_value = DOOR_LOAD;
                    end
                    default: ;
                endcase
            end
            TRAVEL: begin
                if (zero) begin
                    floor_n    = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
                    moving_n   = 1'b0;
                    state_n    = SETTLE;
                    load       = 1'b1;
                    load_value = SETTLE_LOAD;
                end
            end
            DOOR: begin
                if (zero) begin
                    door_n     = 1'b0;
                    pulse_n    = 1'b1;
                    state_n    = SETTLE;
                    load       = 1'b1;
                    load_value = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (zero) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign bus.cur_floor    = floor_q;
    assign bus.moving       = moving_q;
    assign bus.dir_up       = dir_q;
    assign bus.door_open    = door_q;
    assign bus.served_pulse = pulse_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_elevator_body.sv
// Scoreboard bench for elevator_body: floor/serve events checked by cycle.
module tb_elevator_body;
    import elevator_pkg::*;

    localparam int N  = 4;
    localparam int FB = 2;
    localparam int EV_FLOOR = 0;
    localparam int EV_SERVE = 1;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc        = 0;
    int   n_pass     = 0;
    int   n_chk      = 0;
    int   prev_floor = 0;
    ev_t  exp_q[$];

    elevator_if #(.F_BITS(FB)) bus ();

    elevator_body #(
        .N             (N),
        .F_BITS        (FB),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (6),
        .SETTLE_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     tag, got, want, cyc);
        else
            n_pass++;
    endtask

    task automatic expect_ev(input int k, input int v, input int at);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("ev_unexpected", k, -1);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_val", v, e.val);
            chk("ev_cyc", cyc, e.at);
        end
    endtask

    // Event monitor: every floor change and served pulse must be expected.
    always @(negedge clk) begin
        if (int'(bus.cur_floor) != prev_floor) begin
            observe(EV_FLOOR, int'(bus.cur_floor));
            prev_floor = int'(bus.cur_floor);
        end
        if (bus.served_pulse === 1'b1) observe(EV_SERVE, 0);
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) chk("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic issue(input logic [1:0] cmd, output int c);
        @(negedge clk);
        c = cyc;
        bus.command = cmd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int k;
        bus.command = CMD_IDLE;
        #12;
        chk("rst_floor", int'(bus.cur_floor), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_moving", int'(bus.moving), 0);
        chk("rst_door", int'(bus.door_open), 0);
        chk("rst_pulse", int'(bus.served_pulse), 0);
        chk("rst_dir", int'(bus.dir_up), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Held up command: two back-to-back travels.
        issue(CMD_UP, c);
        expect_ev(EV_FLOOR, 1, c + 9);
        expect_ev(EV_FLOOR, 2, c + 21);
        @(negedge clk);
        chk("t1_moving", int'(bus.moving), 1);
        chk("t1_busy", int'(bus.busy), 1);
        chk("t1_dir", int'(bus.dir_up), 1);
        repeat (7) @(negedge clk);
        chk("t1_floor_hold", int'(bus.cur_floor), 0);
        chk("t1_moving_late", int'(bus.moving), 1);
        @(negedge clk);
        chk("t1_floor1", int'(bus.cur_floor), 1);
        chk("t1_moving_off", int'(bus.moving), 0);
        chk("t1_settle_busy0", int'(bus.busy), 1);
        repeat (2) @(negedge clk);
        chk("t1_settle_busy2", int'(bus.busy), 1);
        @(negedge clk);
        chk("t1_idle", int'(bus.busy), 0);
        @(negedge clk);
        chk("t1_moving2", int'(bus.moving), 1);
        bus.command = CMD_IDLE;
        wait_idle();
        chk("t1_floor2", int'(bus.cur_floor), 2);

        // Held serve: no pulse during settle, a second serve on resample.
        issue(CMD_SERVE, c);
        expect_ev(EV_SERVE, 0, c + 7);
        expect_ev(EV_SERVE, 0, c + 17);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_door", int'(bus.door_open), 1);
        end
        @(negedge clk);
        chk("t2_door_fall", int'(bus.door_open), 0);
        chk("t2_pulse", int'(bus.served_pulse), 1);
        chk("t2_busy", int'(bus.busy), 1);
        @(negedge clk);
        chk("t2_pulse_once", int'(bus.served_pulse), 0);
        repeat (3) @(negedge clk);
        chk("t2_reserve", int'(bus.door_open), 1);
        bus.command = CMD_IDLE;
        wait_idle();

        // Saturation at the top floor.
        issue(CMD_UP, c);
        expect_ev(EV_FLOOR, 3, c + 9);
        @(negedge clk);
        bus.command = CMD_IDLE;
        wait_idle();
        bus.command = CMD_UP;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_top_busy", int'(bus.busy), 0);
            chk("t3_top_floor", int'(bus.cur_floor), 3);
        end
        bus.command = CMD_IDLE;

        // Asynchronous reset in the middle of a serve.
        issue(CMD_SERVE, c);
        @(negedge clk);
        bus.command = CMD_IDLE;
        repeat (2) @(negedge clk);
        chk("t4_door_pre", int'(bus.door_open), 1);
        k = cyc;
        expect_ev(EV_FLOOR, 0, k + 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_floor", int'(bus.cur_floor), 0);
        chk("t4_door", int'(bus.door_open), 0);
        chk("t4_busy", int'(bus.busy), 0);
        chk("t4_dir", int'(bus.dir_up), 0);
        chk("t4_pulse", int'(bus.served_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t4_after_door", int'(bus.door_open), 0);

        // Saturation at the bottom floor.
        bus.command = CMD_DOWN;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_bot_busy", int'(bus.busy), 0);
            chk("t5_bot_moving", int'(bus.moving), 0);
        end
        chk("t5_bot_floor", int'(bus.cur_floor), 0);
        bus.command = CMD_IDLE;

        // Controller-style sequence: up, up (with noise), serve.
        issue(CMD_UP, c);
        expect_ev(EV_FLOOR, 1, c + 9);
        @(negedge clk);
        bus.command = CMD_IDLE;
        wait_idle();
        issue(CMD_UP, c);
        expect_ev(EV_FLOOR, 2, c + 9);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.command = (i <= 5) ? CMD_DOWN : CMD_SERVE;
            chk("t6_no_door", int'(bus.door_open), 0);
            chk("t6_dir", int'(bus.dir_up), 1);
        end
        @(negedge clk);
        bus.command = CMD_IDLE;
        wait_idle();
        chk("t6_floor2", int'(bus.cur_floor), 2);
        issue(CMD_SERVE, c);
        expect_ev(EV_SERVE, 0, c + 7);
        @(negedge clk);
        bus.command = CMD_IDLE;
        wait_idle();
        chk("t6_final_floor", int'(bus.cur_floor), 2);
        chk("t6_final_door", int'(bus.door_open), 0);

        repeat (5) @(negedge clk);
        chk("ev_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/elevator_body.md
Name: elevator_body

Overview:
- Cab/motor model that executes the 2-bit command stream from the elevator controller.
- Moves one floor per accepted up/down command and holds the door open on a serve command.
- Reports the current floor to the controller, plus a one-cycle served_pulse when a serve completes.
- Sits between the controller and the floor-indicator/door logic. It is the execution end of the command/served handshake.

Parameters:
- N, 4, number of floors (floors 0..N-1).
- F_BITS, $clog2(N), floor index width.
- TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, 6, clock cycles the door stays open per serve (>=1).
- SETTLE_CYCLES, 3, cycles after any completed action during which commands are ignored (>=1); covers controller clear/flip-flop latency.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- command  input  2  00 idle, 01 up, 10 down, 11 serve
- cur_floor  output  F_BITS  current floor index
- served_pulse  output  1  one-cycle pulse when door closes after a serve
- moving  output  1  high while travelling
- dir_up  output  1  during travel: 1 = up, 0 = down; holds last value otherwise
- door_open  output  1  high while serving
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, cur_floor=0, served_pulse=0, moving=0, dir_up=0, door_open=0, busy=0, counter=0.
- All outputs are registered.
- FSM states: IDLE, TRAVEL, DOOR, SETTLE.
- IDLE: command is sampled every cycle.
  - 01 with cur_floor<N-1: go to TRAVEL, dir_up=1, moving=1, counter=TRAVEL_CYCLES-1.
  - 10 with cur_floor>0: go to TRAVEL, dir_up=0, moving=1, counter=TRAVEL_CYCLES-1.
  - 11: go to DOOR, door_open=1, counter=DOOR_CYCLES-1.
  - 00: stay in IDLE.
  - 01 at floor N-1 or 10 at floor 0: ignored, stay in IDLE, no state change. These are saturation boundaries; cur_floor never wraps.
- TRAVEL: counter decrements each cycle. When counter==0:
  - cur_floor increments (dir_up=1) or decrements (dir_up=0) in that same edge.
  - moving goes low and the FSM goes to SETTLE with counter=SETTLE_CYCLES-1.
  - Latency: cur_floor changes exactly TRAVEL_CYCLES cycles after the IDLE cycle that accepted the command.
- DOOR: counter decrements. When counter==0:
  - door_open goes low, served_pulse=1 for exactly that next cycle.
  - The FSM goes to SETTLE with counter=SETTLE_CYCLES-1.
- SETTLE: command is ignored. Counter decrements; at 0 the FSM returns to IDLE.
- Commands arriving in TRAVEL, DOOR or SETTLE are ignored. There is no abort and no queuing, and the command must still be present when IDLE samples it.
- busy=1 in TRAVEL, DOOR and SETTLE.
- served_pulse is never asserted outside the DOOR→SETTLE transition cycle.
- Reset mid-operation: an immediate return to reset values. The cab is treated as re-homed to floor 0, and no served_pulse is produced for an interrupted serve.
- Counter width is $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES, SETTLE_CYCLES)+1).
- cur_floor arithmetic is F_BITS-wide. The guards above guarantee no overflow.

Decomposition:
- Shared package elevator_pkg:
  - Command encodings CMD_IDLE=2'b00, CMD_UP=2'b01, CMD_DOWN=2'b10, CMD_SERVE=2'b11.
  - Body state enum (IDLE/TRAVEL/DOOR/SETTLE).
  - The controller uses the same CMD_* constants.
- One sub-module is natural: elevator_timer, a loadable down-counter with load, load_value and zero outputs. It is shared by the TRAVEL, DOOR and SETTLE phases.
- The FSM and floor register stay in elevator_body.

Test Plan:
- Reset, then command=01 held, TRAVEL_CYCLES=8 → moving=1 the cycle after acceptance; cur_floor 0→1 exactly 8 cycles after acceptance; then 3 SETTLE cycles with busy=1; then a new travel starts (floor 2).
- command=11 at floor 2, DOOR_CYCLES=6 → door_open=1 for 6 cycles; served_pulse high for exactly one cycle as door_open falls; command=11 still held during SETTLE causes no second pulse until IDLE resamples.
- command=01 at floor 3 (N=4), and command=10 at floor 0 → no state change, busy=0, cur_floor unchanged over 20 cycles.
- During TRAVEL up from floor 1, switch command to 10 then 11 → ignored; arrives at floor 2; no door_open and no served_pulse.
- Assert rst_n=0 asynchronously mid-DOOR at floor 3 → all outputs go to reset values immediately (cur_floor=0, door_open=0); no served_pulse after release.
- Closed loop with the controller: hall-up request at floor 2 from floor 0 → up, up, serve; exactly one served_pulse; the controller's clear_up[2] pulse is observed; the FSM returns to IDLE with command=00.
